// File: rtl/rr_mux4x1.sv
// rr_mux4x1: round-robin reader that drains four first-word-fall-through FIFOs into one downstream FIFO.
// Define RR_BURST_EN to let a grant holder take up to BURST_LEN consecutive pops before yielding.
module rr_mux4x1 #(
   parameter int DATA_W    = 10,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] fifo_data_0,
   input  logic [DATA_W-1:0] fifo_data_1,
   input  logic [DATA_W-1:0] fifo_data_2,
   input  logic [DATA_W-1:0] fifo_data_3,
   input  logic              fifo_empty_0,
   input  logic              fifo_empty_1,
   input  logic              fifo_empty_2,
   input  logic              fifo_empty_3,
   input  logic              out_almost_full,
   output logic              fifo_pop_0,
   output logic              fifo_pop_1,
   output logic              fifo_pop_2,
   output logic              fifo_pop_3,
   output logic [DATA_W-1:0] data_out,
   output logic              push_out,
   output logic [1:0]        sel_out
);

   // state    | meaning
   // ST_IDLE  | no pop was issued in the previous cycle
   // ST_SERVE | a pop was issued in the previous cycle; its word is on data_out now
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_ptr;
   logic [1:0]        r_sel;
   logic [DATA_W-1:0] r_data;

   logic [3:0]        w_req;
   logic              w_pop_ok;
   logic [1:0]        w_rr_grant;
   logic [1:0]        w_grant;
   logic [1:0]        w_idx;
   logic [3:0]        w_pop;
   logic [DATA_W-1:0] w_data;

   assign w_req    = ~{fifo_empty_3, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign w_pop_ok = reset & ~out_almost_full & (|w_req);

   // Walk from the farthest offset back to ptr so the nearest requester wins.
   always_comb begin
      w_rr_grant = r_ptr;
      w_idx      = r_ptr;
      for (int i = 3; i >= 0; i--) begin
         w_idx = r_ptr + 2'(i);
         if (w_req[w_idx]) begin
            w_rr_grant = w_idx;
         end
      end
   end

`ifdef RR_BURST_EN
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   logic [CNT_W-1:0] r_burst_cnt;
   logic             w_hold;

   // A nonzero count means the previous cycle popped r_sel as part of an unfinished burst.
   assign w_hold  = (r_burst_cnt != '0) && w_req[r_sel];
   assign w_grant = w_hold ? r_sel : w_rr_grant;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_burst_cnt <= '0;
      end else if (!w_pop_ok) begin
         r_burst_cnt <= '0;
      end else if (w_hold) begin
         if (r_burst_cnt == CNT_W'(BURST_LEN - 1)) begin
            r_burst_cnt <= '0;
         end else begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
         end
      end else begin
         r_burst_cnt <= (BURST_LEN == 1) ? '0 : CNT_W'(1);
      end
   end
`else
   assign w_grant = w_rr_grant;
`endif

   assign w_pop      = w_pop_ok ? (4'b0001 << w_grant) : 4'b0000;
   assign fifo_pop_0 = w_pop[0];
   assign fifo_pop_1 = w_pop[1];
   assign fifo_pop_2 = w_pop[2];
   assign fifo_pop_3 = w_pop[3];

   always_comb begin
      w_data = fifo_data_0;
      case (w_grant)
         2'd0:    w_data = fifo_data_0;
         2'd1:    w_data = fifo_data_1;
         2'd2:    w_data = fifo_data_2;
         default: w_data = fifo_data_3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = ST_IDLE;
      case (r_state)
         ST_IDLE:  w_state_nxt = w_pop_ok ? ST_SERVE : ST_IDLE;
         ST_SERVE: w_state_nxt = w_pop_ok ? ST_SERVE : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr  <= 2'd0;
         r_sel  <= 2'd0;
         r_data <= '0;
      end else if (w_pop_ok) begin
         r_ptr  <= w_grant + 2'd1;
         r_sel  <= w_grant;
         r_data <= w_data;
      end
   end

   // SERVE is entered exactly on the edge that captures a popped word.
   assign push_out = (r_state == ST_SERVE);
   assign data_out = r_data;
   assign sel_out  = r_sel;

endmodule
